// File: rtl/msx_block_loader.sv
// Copies block_count blocks from DDR3 (store_address) into SDRAM/BRAM (mem_offset),
// one byte at a time: a DDR3 read handshake followed by an SDRAM write handshake.
module msx_block_loader #(
  parameter int BLOCK_SHIFT = 14,
  parameter int DDR_AW      = 28,
  parameter int MEM_AW      = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DDR_AW-1:0] store_address,
  input  logic [MEM_AW-1:0] mem_offset,
  input  logic [7:0]        block_count,
  output logic              busy,
  output logic              done,
  output logic [DDR_AW-1:0] ddr_addr,
  output logic              ddr_rd,
  input  logic [7:0]        ddr_dout,
  input  logic              ddr_ready,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_we,
  input  logic              mem_ready
);

  localparam int CW = 8 + BLOCK_SHIFT;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state_reg, state_next;
  logic [DDR_AW-1:0] src_reg, src_next;
  logic [MEM_AW-1:0] dst_reg, dst_next;
  logic [CW-1:0]     remaining_reg, remaining_next;
  logic [7:0]        data_reg, data_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      src_reg       <= '0;
      dst_reg       <= '0;
      remaining_reg <= '0;
      data_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      src_reg       <= src_next;
      dst_reg       <= dst_next;
      remaining_reg <= remaining_next;
      data_reg      <= data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    src_next       = src_reg;
    dst_next       = dst_reg;
    remaining_next = remaining_reg;
    data_next      = data_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          src_next       = store_address;
          dst_next       = mem_offset;
          remaining_next = CW'(block_count) << BLOCK_SHIFT;
          state_next     = (block_count != 8'd0) ? READ : DONE;
        end
      end
      READ: begin
        if (ddr_ready) begin
          data_next  = ddr_dout;
          src_next   = src_reg + DDR_AW'(1);
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (mem_ready) begin
          dst_next       = dst_reg + MEM_AW'(1);
          remaining_next = remaining_reg - CW'(1);
          // Last byte of the image goes straight to DONE.
          state_next     = (remaining_reg == CW'(1)) ? DONE : READ;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Address/data registers are driven continuously; they only change on
  // handshake edges, so they are stable while a request waits.
  assign busy     = (state_reg == READ) || (state_reg == WRITE);
  assign done     = (state_reg == DONE);
  assign ddr_rd   = (state_reg == READ);
  assign mem_we   = (state_reg == WRITE);
  assign ddr_addr = src_reg;
  assign mem_addr = dst_reg;
  assign mem_din  = data_reg;

endmodule
